// File: rtl/dilithium_pkg.sv
// Shared Dilithium constants and FSM state encoding for the NTT-domain datapath.
package dilithium_pkg;

   localparam int unsigned N      = 256;
   localparam int unsigned DATA_W = 24;
   localparam int unsigned ADDR_W = 16;
   localparam logic [23:0] Q_MOD  = 24'd8380417;
   localparam int unsigned Q_W    = 23;
   // floor(2^48 / Q_MOD) for Barrett reduction of 48-bit products
   localparam logic [25:0] MU     = 26'((64'd1 << 48) / 64'(Q_MOD));

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DRAIN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/mod_q_reduce.sv
// Combinational Barrett reduction of a 48-bit value modulo Q; exact for any input.
module mod_q_reduce
   import dilithium_pkg::*;
#(
   parameter logic [23:0] Q = Q_MOD
) (
   input  logic [47:0]    x,
   output logic [Q_W-1:0] r
);

   localparam logic [25:0] M = 26'((64'd1 << 48) / 64'(Q));

   logic [25:0] qhat;
   logic [24:0] r0;
   logic [24:0] r1;
   logic [24:0] r2;

   // qhat undershoots floor(x/Q) by at most one, so r0 < 2Q; two subtracts give margin
   always_comb begin
      qhat = 26'((74'(x) * 74'(M)) >> 48);
      r0   = 25'(x - 48'(qhat) * 48'(Q));
      r1   = (r0 >= 25'(Q)) ? r0 - 25'(Q) : r0;
      r2   = (r1 >= 25'(Q)) ? r1 - 25'(Q) : r1;
      r    = Q_W'(r2);
   end

endmodule

// File: rtl/pointwise_mul_fsm.sv
// Streams a_hat and b_hat from SRAM, writes c[i] = a[i]*b[i] mod q; done pulse starts the INTT.
module pointwise_mul_fsm #(
   parameter int unsigned        N      = dilithium_pkg::N,
   parameter logic [23:0]        Q_MOD  = dilithium_pkg::Q_MOD,
   parameter int unsigned        ADDR_W = dilithium_pkg::ADDR_W,
   parameter int unsigned        DATA_W = dilithium_pkg::DATA_W,
   parameter logic [ADDR_W-1:0]  A_BASE = '0,
   parameter logic [ADDR_W-1:0]  B_BASE = '0,
   parameter logic [ADDR_W-1:0]  C_BASE = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] A_a,
   input  logic [DATA_W-1:0] Q_a,
   output logic [ADDR_W-1:0] A_b,
   input  logic [DATA_W-1:0] Q_b,
   output logic [ADDR_W-1:0] A_c,
   output logic [DATA_W-1:0] D_c,
   output logic              WEB_c
);

   import dilithium_pkg::*;

   localparam int unsigned P_W = 2 * DATA_W;

   state_t              state;
   state_t              state_nx;
   logic [ADDR_W-1:0]   rd_cnt;
   logic [ADDR_W-1:0]   rd_cnt_nx;
   logic [1:0]          drain_cnt;
   logic [1:0]          drain_cnt_nx;
   logic                issue;
   logic                v1;
   logic                v2;
   logic [ADDR_W-1:0]   idx1;
   logic [ADDR_W-1:0]   idx2;
   logic [P_W-1:0]      prod;
   logic [Q_W-1:0]      red;

   assign A_a  = A_BASE + rd_cnt;
   assign A_b  = B_BASE + rd_cnt;
   assign busy = (state == ST_RUN) || (state == ST_DRAIN);
   assign done = (state == ST_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_IDLE;
         rd_cnt    <= '0;
         drain_cnt <= '0;
      end else begin
         state     <= state_nx;
         rd_cnt    <= rd_cnt_nx;
         drain_cnt <= drain_cnt_nx;
      end
   end

   always_comb begin
      state_nx     = state;
      rd_cnt_nx    = rd_cnt;
      drain_cnt_nx = drain_cnt;
      issue        = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (start) begin
               state_nx  = ST_RUN;
               rd_cnt_nx = '0;
            end
         end
         ST_RUN: begin
            issue     = 1'b1;
            rd_cnt_nx = rd_cnt + ADDR_W'(1);
            if (rd_cnt == ADDR_W'(N - 1)) begin
               state_nx     = ST_DRAIN;
               drain_cnt_nx = '0;
            end
         end
         ST_DRAIN: begin
            drain_cnt_nx = drain_cnt + 2'd1;
            if (drain_cnt == 2'd2)
               state_nx = ST_DONE;
         end
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   mod_q_reduce #(
      .Q (Q_MOD)
   ) u_reduce (
      .x (prod),
      .r (red)
   );

   // v1: SRAM data valid, v2: product valid, write stage drives WEB_c/A_c/D_c
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v1    <= 1'b0;
         v2    <= 1'b0;
         idx1  <= '0;
         idx2  <= '0;
         prod  <= '0;
         WEB_c <= 1'b1;
         A_c   <= C_BASE;
         D_c   <= '0;
      end else begin
         v1    <= issue;
         idx1  <= rd_cnt;
         v2    <= v1;
         idx2  <= idx1;
         prod  <= P_W'(Q_a) * P_W'(Q_b);
         WEB_c <= ~v2;
         if (v2) begin
            A_c <= C_BASE + idx2;
            D_c <= DATA_W'(red);
         end
      end
   end

endmodule

// File: tb/tb_pointwise_mul_fsm.sv
// Scoreboard bench: SRAM models feed the DUT; a negedge monitor checks every result write.
module tb_pointwise_mul_fsm;

   localparam int unsigned QV = 8380417;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        busy, done, WEB_c;
   logic [15:0] A_a, A_b, A_c;
   logic [23:0] Q_a, Q_b, D_c;

   logic        busy_w, done_w, WEB_c_w;
   logic [15:0] A_a_w, A_b_w, A_c_w;
   logic [23:0] D_c_w;
   logic [23:0] Q_zero = '0;

   logic [23:0] mem_a [0:65535];
   logic [23:0] mem_b [0:65535];
   logic [23:0] exp_c [0:255];

   typedef struct {
      logic [15:0] addr;
      logic [23:0] data;
   } wr_t;

   wr_t sb[$];
   int  done_q[$];
   int  cyc = 0;
   int  wr_cnt = 0;
   int  first_wr = -1;
   int  checks = 0;
   int  errors = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      Q_a <= mem_a[A_a];
      Q_b <= mem_b[A_b];
   end

   pointwise_mul_fsm dut (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
      .A_a(A_a), .Q_a(Q_a), .A_b(A_b), .Q_b(Q_b),
      .A_c(A_c), .D_c(D_c), .WEB_c(WEB_c)
   );

   pointwise_mul_fsm #(.A_BASE(16'hFFF0)) dut_w (
      .clk(clk), .rst_n(rst_n), .start(start), .busy(busy_w), .done(done_w),
      .A_a(A_a_w), .Q_a(Q_zero), .A_b(A_b_w), .Q_b(Q_zero),
      .A_c(A_c_w), .D_c(D_c_w), .WEB_c(WEB_c_w)
   );

   always @(negedge clk) begin
      if (rst_n) begin
         if (!WEB_c) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            checks++;
            if (sb.size() == 0) begin
               errors++;
               $display("FAIL unexpected_write: A_c=%0d D_c=%0d, required no write", A_c, D_c);
            end else begin
               wr_t e;
               e = sb.pop_front();
               if (A_c !== e.addr || D_c !== e.data) begin
                  errors++;
                  $display("FAIL c_write: A_c=%0d D_c=%0d, required A_c=%0d D_c=%0d",
                           A_c, D_c, e.addr, e.data);
               end
            end
         end
         if (done) done_q.push_back(cyc);
      end
   end

   task automatic check(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic load(input int mode);
      logic [23:0] a, b;
      for (int i = 0; i < 256; i++) begin
         case (mode)
            0: begin a = 24'(i); b = 24'd1; exp_c[i] = 24'(i); end
            1: begin a = 24'd8380416; b = 24'd8380416; exp_c[i] = 24'd1; end
            2: begin a = 24'd0; b = 24'(i * 1000 + 7); exp_c[i] = 24'd0; end
            3: begin a = 24'hFFFFFF; b = 24'hFFFFFF; exp_c[i] = 24'd163817; end
            default: begin
               a = 24'($urandom_range(0, QV - 1));
               b = 24'($urandom_range(0, QV - 1));
               exp_c[i] = 24'((longint'(a) * longint'(b)) % longint'(QV));
            end
         endcase
         mem_a[i] = a;
         mem_b[i] = b;
      end
   endtask

   task automatic push_exp();
      for (int i = 0; i < 256; i++) begin
         wr_t e;
         e.addr = 16'(i);
         e.data = exp_c[i];
         sb.push_back(e);
      end
   endtask

   task automatic run(input string tag, input int n_runs, input bit hold,
                      input bit pulses, input bit chk_wrap);
      int k, u;
      wr_cnt = 0;
      first_wr = -1;
      done_q.delete();
      for (int r = 0; r < n_runs; r++) push_exp();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      k = cyc;
      if (!hold) start = 1'b0;
      check({tag, "_busy_first"}, busy, 1);
      for (;;) begin
         u = cyc - k;
         if (u == 0)   check({tag, "_A_a_first"}, A_a, 0);
         if (u == 255) check({tag, "_A_a_last"}, A_a, 255);
         if (chk_wrap) begin
            if (u == 0)   check("wrap_A_a_0", A_a_w, 16'hFFF0);
            if (u == 15)  check("wrap_A_a_15", A_a_w, 16'hFFFF);
            if (u == 16)  check("wrap_A_a_16", A_a_w, 16'h0000);
            if (u == 255) check("wrap_A_a_255", A_a_w, 16'h00EF);
         end
         if (pulses) start = (u == 10 || u == 255 || u == 257 || u == 259);
         if (done_q.size() >= n_runs || u >= 700) break;
         @(negedge clk);
      end
      start = 1'b0;
      repeat (20) @(negedge clk);
      check({tag, "_done_count"}, done_q.size(), n_runs);
      if (done_q.size() > 0) check({tag, "_done_cycle"}, done_q[0], k + 259);
      if (n_runs == 2 && done_q.size() > 1) check({tag, "_done2_cycle"}, done_q[1], k + 520);
      check({tag, "_first_write_cycle"}, first_wr, k + 3);
      check({tag, "_write_count"}, wr_cnt, 256 * n_runs);
      check({tag, "_sb_empty"}, sb.size(), 0);
      check({tag, "_busy_after"}, busy, 0);
   endtask

   task automatic reset_mid_run();
      int k;
      wr_cnt = 0;
      push_exp();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      k = cyc;
      start = 1'b0;
      while (cyc < k + 98) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("rst_mid_WEB_c", WEB_c, 1);
      check("rst_mid_busy", busy, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_writes_before", wr_cnt, 96);
      sb.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (12) @(negedge clk);
      check("rst_mid_no_writes_after", wr_cnt, 96);
      check("rst_mid_busy_idle", busy, 0);
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

   initial begin
      void'($urandom(32'd20240611));
      repeat (3) @(negedge clk);
      check("reset_WEB_c", WEB_c, 1);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_A_c", A_c, 0);
      check("reset_D_c", D_c, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      load(0); run("ident", 1, 1'b0, 1'b0, 1'b1);
      load(1); run("qm1", 1, 1'b0, 1'b0, 1'b0);
      load(2); run("zero", 1, 1'b0, 1'b0, 1'b0);
      load(3); run("noncanon", 1, 1'b0, 1'b0, 1'b0);
      load(4); run("rand_b2b", 2, 1'b1, 1'b0, 1'b0);
      load(0); run("pulses", 1, 1'b0, 1'b1, 1'b0);
      load(3); reset_mid_run();
      load(4); run("after_rst", 1, 1'b0, 1'b0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pointwise_mul_fsm.md
Name: pointwise_mul_fsm

Overview:
- NTT-domain pointwise multiplier; the stage directly upstream of the inverse-NTT engine.
- Streams two 256-coefficient polynomials (a_hat, b_hat) out of synchronous SRAMs.
- Computes c[i] = a[i]*b[i] mod q (q = 8380417) and writes c into the buffer the INTT engine later reads.
- The done pulse is the INTT start trigger.

Parameters:
N, 256, coefficients per polynomial
Q_MOD, 8380417, Dilithium modulus
ADDR_W, 16, SRAM address width
DATA_W, 24, SRAM data width
A_BASE, 0, base address of a_hat
B_BASE, 0, base address of b_hat
C_BASE, 0, base address of result c

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin operation; sampled only in IDLE
busy  out  1  high from first RUN cycle through last DRAIN cycle
done  out  1  one-cycle pulse after last write
A_a  out  ADDR_W  read address, a_hat SRAM
Q_a  in  DATA_W  read data, a_hat SRAM (1-cycle read latency)
A_b  out  ADDR_W  read address, b_hat SRAM
Q_b  in  DATA_W  read data, b_hat SRAM (1-cycle read latency)
A_c  out  ADDR_W  write address, result SRAM
D_c  out  DATA_W  write data (bits 23 of value always 0; value in [0,q-1])
WEB_c  out  1  active-low write enable, result SRAM

Behaviour:
- Reset is asynchronous and active-low on rst_n; clock is clk.
- Reset values: state IDLE, rd_cnt=0, busy=0, done=0, WEB_c=1, A_c=C_BASE, D_c=0, pipeline valids 0.
- A_a = A_BASE + rd_cnt and A_b = B_BASE + rd_cnt, combinationally.
- States and transitions:
  - IDLE: start=1 -> RUN, rd_cnt=0. Otherwise stay.
  - RUN: rd_cnt increments each cycle; issue valid=1. At rd_cnt=N-1 -> DRAIN.
  - DRAIN: 3 cycles with issue valid=0 while the pipeline empties -> DONE.
  - DONE: done=1 for this cycle only -> IDLE.
- Pipeline, registered at every stage:
  - V1: SRAM read returns.
  - V2: 48-bit product P = Q_a*Q_b, registered.
  - V3: R = P mod Q_MOD via mod_q_reduce, registered into D_c, with A_c = C_BASE + index and WEB_c=0.
- Timing: if start is sampled at edge k:
  - first read address appears in cycle k+1;
  - c[0] is written in cycle k+4;
  - c[i] is written in cycle k+4+i;
  - last write is in cycle k+259;
  - done=1 in cycle k+260.
- Throughput 1 coefficient/cycle. Exactly N cycles with WEB_c=0 per run. Addresses strictly ascending, no gaps.
- Arithmetic: full 24x24 unsigned product (<2^48). Reduction is exact for ANY 24-bit inputs, including non-canonical values >= q. Output is always canonical in [0,q-1].
- WEB_c=1 in every cycle without a valid V3 entry.
- start while busy or in DONE is ignored. start held high through DONE starts a new run from IDLE on the next sampling edge. There is no queueing.
- Reset mid-operation: immediate return to IDLE, WEB_c=1 asynchronously, valids cleared, no further writes. A partially written c is left as is.
- rd_cnt is ADDR_W wide. Base+offset is computed modulo 2^ADDR_W (wrap, no saturation).

Decomposition:
- Shared package (dilithium_pkg): Q_MOD=8380417, N=256, DATA_W=24, ADDR_W=16, Barrett constant MU=floor(2^48/Q_MOD), state encodings.
- Sub-module mod_q_reduce:
  - Purely combinational; 48-bit in, 23-bit out.
  - Barrett estimate followed by up to two conditional subtracts of Q_MOD.
  - Reusable later by the INTT datapath reducers.

Test Plan:
- a[i]=i, b[i]=1, i=0..255, start pulse at edge k -> c[i]=i. First WEB_c low in cycle k+4; done only in cycle k+260; exactly 256 write cycles.
- a[i]=b[i]=8380416 (q-1) -> every c[i]=1. a[i]=0 -> every c[i]=0.
- a[i]=b[i]=24'hFFFFFF (non-canonical) -> every c[i]=163817.
- Random canonical a,b, seeded -> c matches reference model (a*b)%8380417. Two back-to-back runs with start held high -> second run begins the cycle after IDLE re-entry.
- rst_n low at cycle k+100 -> WEB_c=1, busy=0 immediately; no writes until next start. Next full run is correct.
- start pulses during RUN/DRAIN -> ignored: single done, 256 writes, addresses unchanged. Base wrap: A_BASE=16'hFFF0 -> A_a wraps to 0 after 16 reads.
